// File: rtl/remote_comm_pkg.sv
// Shared definitions for the host-side flight-controller command link:
// baud default, command codes, the ACK byte and the send-sequencer states.
package remote_comm_pkg;

    localparam int BAUD_DIV_DEFAULT = 2604;

    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] SET_CAL   = 8'h06;
    localparam logic [7:0] SET_EMGL  = 8'h07;
    localparam logic [7:0] SET_MOFF  = 8'h08;

    localparam logic [7:0] ACK = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        HIGH,
        LOW
    } send_state_t;

    // Baud counters never shrink below 12 bits so the default divider always fits.
    function automatic int baud_cnt_width(input int div);
        return ($clog2(div + 1) > 12) ? $clog2(div + 1) : 12;
    endfunction

endpackage

// File: rtl/remote_comm_if.sv
// Host-facing command/response bundle of the remote_comm link.
interface remote_comm_if;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        send_cmd;
    logic        cmd_sent;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        clr_resp_rdy;

    modport master (
        output cmd, data, send_cmd, clr_resp_rdy,
        input  cmd_sent, resp, resp_rdy
    );

    modport slave (
        input  cmd, data, send_cmd, clr_resp_rdy,
        output cmd_sent, resp, resp_rdy
    );
endinterface

// File: rtl/remote_comm_uart.sv
// 8N1 UART: transmitter with single-cycle restart for back-to-back bytes, and an
// independent receiver with a two-flop synchronizer and midpoint sampling.
module remote_comm_uart
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       tx_done,
    output logic       TX,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rdy,
    input  logic       clr_rdy
);

    localparam int             CW         = baud_cnt_width(BAUD_DIV);
    localparam logic [CW-1:0]  BAUD_LAST  = CW'(BAUD_DIV - 1);
    // Start detection costs one cycle after the synchronizer, hence the -2.
    localparam logic [CW-1:0]  HALF_START = CW'(BAUD_DIV / 2 - 2);
    localparam int             SYNC_STAGES = 2;

    // ---------------- transmitter ----------------
    logic [9:0]    tx_shift_reg;
    logic [CW-1:0] tx_cnt_reg;
    logic [3:0]    tx_bit_reg;
    logic          tx_busy_reg;

    assign tx_done = tx_busy_reg && (tx_cnt_reg == BAUD_LAST) && (tx_bit_reg == 4'd9);
    assign TX      = tx_shift_reg[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift_reg <= '1;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_busy_reg  <= 1'b0;
        end else if (trmt) begin
            tx_shift_reg <= {1'b1, tx_data, 1'b0};
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_busy_reg  <= 1'b1;
        end else if (tx_busy_reg) begin
            if (tx_cnt_reg == BAUD_LAST) begin
                tx_cnt_reg <= '0;
                if (tx_bit_reg == 4'd9) begin
                    tx_busy_reg <= 1'b0;
                end else begin
                    tx_bit_reg   <= tx_bit_reg + 4'd1;
                    tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
                end
            end else begin
                tx_cnt_reg <= tx_cnt_reg + 1'b1;
            end
        end
    end

    // ---------------- receiver ----------------
    logic [SYNC_STAGES-1:0] rx_sync_reg;
    logic                   rx_sync;
    logic                   rx_prev_reg;
    logic                   rx_busy_reg;
    logic [CW-1:0]          rx_cnt_reg;
    logic [3:0]             rx_bit_reg;
    logic [7:0]             rx_shift_reg;
    logic [7:0]             rx_data_reg;
    logic                   rdy_reg;
    logic                   rx_sample;
    logic                   rx_done;

    assign rx_sync   = rx_sync_reg[SYNC_STAGES-1];
    assign rx_sample = rx_busy_reg && (rx_cnt_reg == '0);
    assign rx_done   = rx_sample && (rx_bit_reg == 4'd9) && rx_sync;
    assign rx_data   = rx_data_reg;
    assign rdy       = rdy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_reg  <= '1;
            rx_prev_reg  <= 1'b1;
            rx_busy_reg  <= 1'b0;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            rdy_reg      <= 1'b0;
        end else begin
            rx_sync_reg <= {rx_sync_reg[SYNC_STAGES-2:0], RX};
            rx_prev_reg <= rx_sync;

            if (!rx_busy_reg) begin
                if (rx_prev_reg && !rx_sync) begin
                    rx_busy_reg <= 1'b1;
                    rx_cnt_reg  <= HALF_START;
                    rx_bit_reg  <= '0;
                end
            end else if (!rx_sample) begin
                rx_cnt_reg <= rx_cnt_reg - 1'b1;
            end else begin
                rx_cnt_reg <= BAUD_LAST;
                rx_bit_reg <= rx_bit_reg + 4'd1;
                if (rx_bit_reg == 4'd0) begin
                    // A start bit that is high at its midpoint was only a glitch.
                    if (rx_sync) rx_busy_reg <= 1'b0;
                end else if (rx_bit_reg == 4'd9) begin
                    rx_busy_reg <= 1'b0;
                end else begin
                    rx_shift_reg <= {rx_sync, rx_shift_reg[7:1]};
                end
            end

            if (rx_done) rx_data_reg <= rx_shift_reg;

            if (rx_done)      rdy_reg <= 1'b1;
            else if (clr_rdy) rdy_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/remote_comm.sv
// Host command link: sequences cmd, data[15:8], data[7:0] out of the UART and
// exposes the last framed response byte from the flight controller.
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RX,
    output logic          TX,
    remote_comm_if.slave  host
);

    send_state_t state_reg, state_next;
    logic [7:0]  cmd_reg;
    logic [15:0] data_reg;
    logic        cmd_sent_reg;

    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        load;
    logic        set_sent;
    logic [7:0]  resp;
    logic        resp_rdy;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (host.send_cmd) state_next = CMD;
            CMD:     if (tx_done)       state_next = HIGH;
            HIGH:    if (tx_done)       state_next = LOW;
            LOW:     if (tx_done)       state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // The first byte comes straight from the port so the start bit leaves on the
    // cycle after send_cmd; later bytes come from the latched copy.
    always_comb begin
        trmt     = 1'b0;
        tx_data  = cmd_reg;
        load     = 1'b0;
        set_sent = 1'b0;
        case (state_reg)
            IDLE: if (host.send_cmd) begin
                trmt    = 1'b1;
                tx_data = host.cmd;
                load    = 1'b1;
            end
            CMD: if (tx_done) begin
                trmt    = 1'b1;
                tx_data = data_reg[15:8];
            end
            HIGH: if (tx_done) begin
                trmt    = 1'b1;
                tx_data = data_reg[7:0];
            end
            LOW: if (tx_done) set_sent = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_reg      <= '0;
            data_reg     <= '0;
            cmd_sent_reg <= 1'b0;
        end else begin
            if (load) begin
                cmd_reg  <= host.cmd;
                data_reg <= host.data;
            end
            if (load)          cmd_sent_reg <= 1'b0;
            else if (set_sent) cmd_sent_reg <= 1'b1;
        end
    end

    remote_comm_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .trmt    (trmt),
        .tx_done (tx_done),
        .TX      (TX),
        .RX      (RX),
        .rx_data (resp),
        .rdy     (resp_rdy),
        .clr_rdy (host.clr_resp_rdy)
    );

    assign host.cmd_sent = cmd_sent_reg;
    assign host.resp     = resp;
    assign host.resp_rdy = resp_rdy;

endmodule

// File: tb/tb_remote_comm.sv
// Scoreboard bench for remote_comm: TX frames are decoded by a line monitor and
// compared against bytes queued when each send is issued; RX frames are driven bitwise.
module tb_remote_comm;
    import remote_comm_pkg::*;

    localparam int B = 208;

    logic clk;
    logic rst;
    logic RX;
    logic TX;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [9:0] got_q[$];
    logic [7:0] tx_exp_q[$];
    logic [7:0] resp_exp_q[$];

    remote_comm_if host_if();

    remote_comm #(.BAUD_DIV(B)) dut (
        .clk  (clk),
        .rst  (rst),
        .RX   (RX),
        .TX   (TX),
        .host (host_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: decode each TX frame as {stop, data, start}.
    initial begin
        logic [9:0] fr;
        forever begin
            @(negedge TX);
            repeat (B / 2) @(negedge clk);
            fr[0] = TX;
            for (int i = 1; i < 10; i++) begin
                repeat (B) @(negedge clk);
                fr[i] = TX;
            end
            got_q.push_back(fr);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d expected < 100000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send_pulse(input logic [7:0] c, input logic [15:0] d);
        host_if.cmd      = c;
        host_if.data     = d;
        host_if.send_cmd = 1'b1;
        @(negedge clk);
        host_if.send_cmd = 1'b0;
        host_if.cmd      = ~c;
        host_if.data     = ~d;
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = fr[i];
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
    endtask

    task automatic wait_cmd_sent(output int t);
        int n;
        n = 0;
        while (host_if.cmd_sent !== 1'b1 && n < 40 * B) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
    endtask

    task automatic test_reset();
        int lows;
        rst = 1'b1;
        RX  = 1'b1;
        host_if.cmd = 8'h00; host_if.data = 16'h0000;
        host_if.send_cmd = 1'b0; host_if.clr_resp_rdy = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (TX !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b expected 1", TX); end
        tests_run++;
        if (host_if.cmd_sent !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_sent: got %b expected 0", host_if.cmd_sent); end
        tests_run++;
        if (host_if.resp_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_rdy: got %b expected 0", host_if.resp_rdy); end
        tests_run++;
        if (host_if.resp !== 8'h00) begin tests_failed++; $display("FAIL reset_resp: got %h expected 00", host_if.resp); end
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (TX !== 1'b1) lows++;
        end
        tests_run++;
        if (lows != 0) begin tests_failed++; $display("FAIL reset_idle_tx: %0d non-idle cycles expected 0", lows); end
        $display("[TB] reset checks done");
    endtask

    task automatic test_send_cal();
        int t0, t1, n;
        logic [7:0] e;
        logic [9:0] f;
        tx_exp_q.push_back(SET_CAL);
        tx_exp_q.push_back(8'h12);
        tx_exp_q.push_back(8'h34);
        send_pulse(SET_CAL, 16'h1234);
        tests_run++;
        if (TX !== 1'b0) begin tests_failed++; $display("FAIL send_start_bit: TX=%b expected 0", TX); end
        t0 = cyc;
        wait_cmd_sent(t1);
        tests_run++;
        if (host_if.cmd_sent !== 1'b1 || (t1 - t0) < 30 * B - 1 || (t1 - t0) > 30 * B + 1) begin
            tests_failed++;
            $display("FAIL send_cmd_sent_time: cmd_sent=%b after %0d clocks expected 1 after %0d", host_if.cmd_sent, t1 - t0, 30 * B);
        end
        n = 0;
        while (got_q.size() < 3 && n < 20 * B) begin @(negedge clk); n++; end
        while (tx_exp_q.size() > 0) begin
            e = tx_exp_q.pop_front();
            tests_run++;
            if (got_q.size() == 0) begin
                tests_failed++; $display("FAIL send_frame: no frame decoded, expected byte %h", e);
            end else begin
                f = got_q.pop_front();
                if (f !== {1'b1, e, 1'b0}) begin
                    tests_failed++; $display("FAIL send_frame: got frame %b expected %b", f, {1'b1, e, 1'b0});
                end else $display("[TB] send byte %h ok", e);
            end
        end
    endtask

    task automatic test_rx_ack();
        int t0, t1, n;
        logic [7:0] e;
        resp_exp_q.push_back(ACK);
        t0 = cyc;
        t1 = 0;
        fork
            drive_rx(ACK, 1'b1);
            begin
                n = 0;
                while (host_if.resp_rdy !== 1'b1 && n < 12 * B) begin @(negedge clk); n++; end
                t1 = cyc;
            end
        join
        e = resp_exp_q.pop_front();
        tests_run++;
        if (host_if.resp !== e || host_if.resp_rdy !== 1'b1) begin
            tests_failed++; $display("FAIL rx_ack: resp=%h rdy=%b expected %h rdy=1", host_if.resp, host_if.resp_rdy, e);
        end
        tests_run++;
        if ((t1 - t0) < (19 * B) / 2 - 1 || (t1 - t0) > (19 * B) / 2 + 2) begin
            tests_failed++; $display("FAIL rx_latency: %0d clocks expected about %0d", t1 - t0, (19 * B) / 2 + 2);
        end
        host_if.clr_resp_rdy = 1'b1;
        @(negedge clk);
        host_if.clr_resp_rdy = 1'b0;
        tests_run++;
        if (host_if.resp_rdy !== 1'b0 || host_if.resp !== ACK) begin
            tests_failed++; $display("FAIL rx_clear: rdy=%b resp=%h expected rdy=0 resp=%h", host_if.resp_rdy, host_if.resp, ACK);
        end
        $display("[TB] rx ack latency %0d", t1 - t0);
    endtask

    task automatic test_rx_bad_stop();
        drive_rx(8'h5A, 1'b0);
        repeat (2 * B) @(negedge clk);
        tests_run++;
        if (host_if.resp !== ACK || host_if.resp_rdy !== 1'b0) begin
            tests_failed++; $display("FAIL rx_bad_stop: resp=%h rdy=%b expected %h rdy=0", host_if.resp, host_if.resp_rdy, ACK);
        end
        $display("[TB] rx bad stop frame done");
    endtask

    task automatic test_rx_glitch();
        RX = 1'b0;
        repeat (100) @(negedge clk);
        RX = 1'b1;
        repeat (12 * B) @(negedge clk);
        tests_run++;
        if (host_if.resp !== ACK || host_if.resp_rdy !== 1'b0) begin
            tests_failed++; $display("FAIL rx_glitch: resp=%h rdy=%b expected %h rdy=0", host_if.resp, host_if.resp_rdy, ACK);
        end
        $display("[TB] rx glitch done");
    endtask

    task automatic test_rx_clr_coincide();
        logic seen;
        logic [7:0] e;
        seen = 1'b0;
        resp_exp_q.push_back(8'h3C);
        host_if.clr_resp_rdy = 1'b1;
        fork
            drive_rx(8'h3C, 1'b1);
            for (int i = 0; i < 11 * B; i++) begin
                @(negedge clk);
                if (host_if.resp_rdy === 1'b1) seen = 1'b1;
            end
        join
        host_if.clr_resp_rdy = 1'b0;
        e = resp_exp_q.pop_front();
        tests_run++;
        if (seen !== 1'b1) begin tests_failed++; $display("FAIL rx_set_wins: rdy seen=%b expected 1", seen); end
        tests_run++;
        if (host_if.resp !== e || host_if.resp_rdy !== 1'b0) begin
            tests_failed++; $display("FAIL rx_held_clear: resp=%h rdy=%b expected %h rdy=0", host_if.resp, host_if.resp_rdy, e);
        end
        $display("[TB] rx set-vs-clear done");
    endtask

    task automatic test_back_to_back_ignore();
        int t1, n;
        logic [7:0] e;
        logic [9:0] f;
        tx_exp_q.push_back(SET_PTCH);
        tx_exp_q.push_back(8'h01);
        tx_exp_q.push_back(8'h00);
        send_pulse(SET_PTCH, 16'h0100);
        tests_run++;
        if (host_if.cmd_sent !== 1'b0) begin tests_failed++; $display("FAIL ignore_clear_sent: cmd_sent=%b expected 0", host_if.cmd_sent); end
        repeat (12 * B) @(negedge clk);
        send_pulse(SET_ROLL, 16'hFF80);
        wait_cmd_sent(t1);
        repeat (12 * B) @(negedge clk);
        n = 0;
        tests_run++;
        if (got_q.size() != 3) begin tests_failed++; $display("FAIL ignore_count: %0d frames expected 3", got_q.size()); end
        while (tx_exp_q.size() > 0) begin
            e = tx_exp_q.pop_front();
            tests_run++;
            if (got_q.size() == 0) begin
                tests_failed++; $display("FAIL ignore_frame: no frame decoded, expected byte %h", e);
            end else begin
                f = got_q.pop_front();
                if (f !== {1'b1, e, 1'b0}) begin
                    tests_failed++; $display("FAIL ignore_frame: got frame %b expected %b", f, {1'b1, e, 1'b0});
                end else $display("[TB] overlap byte %h ok", e);
            end
        end
        got_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        int t0, t1, n, lows;
        logic [7:0] e;
        logic [9:0] f;
        send_pulse(SET_EMGL, 16'hABCD);
        repeat (10 * B + B / 2 - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (TX !== 1'b1 || host_if.cmd_sent !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_tx: TX=%b cmd_sent=%b expected TX=1 cmd_sent=0", TX, host_if.cmd_sent);
        end
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 12 * B; i++) begin
            @(negedge clk);
            if (TX !== 1'b1) lows++;
        end
        tests_run++;
        if (lows != 0) begin tests_failed++; $display("FAIL midreset_idle: %0d non-idle cycles expected 0", lows); end
        got_q.delete();
        tx_exp_q.push_back(SET_THRST);
        tx_exp_q.push_back(8'h00);
        tx_exp_q.push_back(8'hFF);
        send_pulse(SET_THRST, 16'h00FF);
        tests_run++;
        if (TX !== 1'b0) begin tests_failed++; $display("FAIL midreset_accept: TX=%b expected 0", TX); end
        t0 = cyc;
        wait_cmd_sent(t1);
        tests_run++;
        if (host_if.cmd_sent !== 1'b1 || (t1 - t0) < 30 * B - 1 || (t1 - t0) > 30 * B + 1) begin
            tests_failed++;
            $display("FAIL midreset_sent_time: cmd_sent=%b after %0d clocks expected 1 after %0d", host_if.cmd_sent, t1 - t0, 30 * B);
        end
        n = 0;
        while (got_q.size() < 3 && n < 20 * B) begin @(negedge clk); n++; end
        while (tx_exp_q.size() > 0) begin
            e = tx_exp_q.pop_front();
            tests_run++;
            if (got_q.size() == 0) begin
                tests_failed++; $display("FAIL midreset_frame: no frame decoded, expected byte %h", e);
            end else begin
                f = got_q.pop_front();
                if (f !== {1'b1, e, 1'b0}) begin
                    tests_failed++; $display("FAIL midreset_frame: got frame %b expected %b", f, {1'b1, e, 1'b0});
                end else $display("[TB] post-reset byte %h ok", e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_send_cal();
        test_rx_ack();
        test_rx_bad_stop();
        test_rx_glitch();
        test_rx_clr_coincide();
        test_back_to_back_ignore();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/remote_comm.md
# remote_comm

Host-side command link for the quadcopter bench environment. It takes an 8-bit command and a 16-bit data word, serializes them over an 8N1 UART as three bytes (cmd, data[15:8], data[7:0]), and receives the single-byte response (e.g. 0xA5 ack) returned by the flight controller. It sits between the host/test stimulus and the flight controller's UART RX/TX pins.

## Interface
- BAUD_DIV, default 2604: clocks per bit (19200 baud at 50 MHz).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd  in  8  command byte, captured on send_cmd.
- data  in  16  data word, captured on send_cmd.
- send_cmd  in  1  one-cycle start pulse.
- cmd_sent  out  1  high once all three bytes have left TX; sticky until next accepted send_cmd.
- RX  in  1  serial input from the flight controller; asynchronous, idle high.
- TX  out  1  serial output to the flight controller; idle high.
- resp  out  8  last correctly framed received byte.
- resp_rdy  out  1  new resp available; sticky.
- clr_resp_rdy  in  1  clears resp_rdy.

## Operation
- Reset values: TX=1, cmd_sent=0, resp_rdy=0, resp=0x00, FSM=IDLE.
- Send FSM states: IDLE, CMD, HIGH, LOW.
  - IDLE: on send_cmd, latch {cmd,data}, clear cmd_sent, start transmitting cmd, go to CMD.
  - CMD: on byte done, start data[15:8], go to HIGH.
  - HIGH: on byte done, start data[7:0], go to LOW.
  - LOW: on byte done, set cmd_sent, go to IDLE.
- send_cmd outside IDLE is ignored; latched values are unchanged.
- Inputs cmd/data may change after the send_cmd cycle.
- TX frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is BAUD_DIV clocks.
- RX path:
  - Double-flop synchronize RX.
  - A falling edge in idle starts reception.
  - Sample at BAUD_DIV/2 into the start bit, then every BAUD_DIV clocks for 8 data bits and the stop bit.
  - If the start bit samples 1 at its midpoint, abort (glitch) and return to idle.
  - If the stop bit samples 1, load resp and set resp_rdy.
  - If the stop bit samples 0, discard the byte; resp and resp_rdy are unchanged.
- clr_resp_rdy clears resp_rdy. If clr_resp_rdy coincides with byte completion, the set wins.
- The receiver runs independently of the send FSM; full duplex.

## Timing
- TX falls (start bit) on the cycle after send_cmd is sampled.
- Bytes are back-to-back: the next start bit begins on the cycle after the previous stop bit's last clock.
- cmd_sent rises 3×10×BAUD_DIV clocks (78120 at default) after TX first falls, ±1 cycle.
- resp_rdy rises within 2 cycles (synchronizer) plus 9.5×BAUD_DIV clocks of the RX start-bit falling edge.
- Reset asserted mid-frame: TX returns to 1 on the next edge, the send FSM aborts to IDLE, and the receiver drops any partial byte.
- Baud counters are at least 12 bits; bit counters are 4 bits and count 0..9.

## Structure
- Shared package holds:
  - default BAUD_DIV;
  - command codes: SET_PTCH 0x02, SET_ROLL 0x03, SET_YAW 0x04, SET_THRST 0x05, SET_CAL 0x06, SET_EMGL 0x07, SET_MOFF 0x08;
  - ACK 0xA5;
  - the send-FSM state enum.
- One sub-module: uart (tx and rx halves, ports tx_data/trmt/tx_done and rx_data/rdy/clr_rdy), parameterized by BAUD_DIV. remote_comm contains only the byte-sequencing FSM, the latches and cmd_sent.

## Test plan
- Reset: TX=1, cmd_sent=0, resp_rdy=0, resp=0x00; hold 100 cycles with no TX activity.
- send_cmd with cmd=0x06, data=0x1234: decoded TX bytes are 0x06, 0x12, 0x34, each with a 0 start bit and a 1 stop bit; cmd_sent rises at 78120±1 clocks after the first start bit.
- Drive a 0xA5 frame on RX: resp=0xA5 and resp_rdy=1 at ~24740 clocks after the start edge. clr_resp_rdy then drops resp_rdy the next cycle while resp stays 0xA5.
- RX frames:
  - A second frame of 0x5A with a 0 stop bit leaves resp=0xA5.
  - A 100-clock low glitch on RX produces no byte.
- send_cmd 0x02/0x0100, then send_cmd 0x03/0xFF80 while the first is in HIGH: TX carries only 0x02, 0x01, 0x00.
- Assert rst during the second byte: TX=1 next cycle and FSM in IDLE. A new send_cmd 0x05/0x00FF then transmits 0x05, 0x00, 0xFF correctly.
